// File: rtl/mem_burst_arbiter_if.sv
// Bundle of the cache-side and memory-side buses around the burst arbiter.
// slave  : arbiter view (takes cache requests, drives the burst port)
// master : environment view (caches plus burst memory)
interface mem_burst_arbiter_if;
    // I-cache side
    logic [31:0]  i_mem_addr;
    logic         i_mem_read;
    logic [255:0] i_mem_rdata;
    logic         i_mem_resp;
    // D-cache side
    logic [31:0]  d_mem_addr;
    logic         d_mem_read;
    logic         d_mem_write;
    logic [255:0] d_mem_wdata;
    logic [255:0] d_mem_rdata;
    logic         d_mem_resp;
    // Physical burst port
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  i_mem_addr, i_mem_read,
        output i_mem_rdata, i_mem_resp,
        input  d_mem_addr, d_mem_read, d_mem_write, d_mem_wdata,
        output d_mem_rdata, d_mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_mem_addr, i_mem_read,
        input  i_mem_rdata, i_mem_resp,
        output d_mem_addr, d_mem_read, d_mem_write, d_mem_wdata,
        input  d_mem_rdata, d_mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: shares one 64-bit burst memory port between the I-cache
// and D-cache. One 256-bit line transaction at a time, split into 4 beats,
// with the line buffered so each cache sees a single-cycle response.
// Build option: define ARB_RR_EN for round-robin on ties; otherwise the
// I-cache always wins a tie.
module mem_burst_arbiter (
    input  logic                clk,
    input  logic                rst,      // asynchronous, active-low
    mem_burst_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t         r_state, w_state_next;
    logic [1:0]     r_cnt, w_cnt_next;
    logic           r_last_grant, w_last_grant_next;
    logic           r_owner, w_owner_next;
    logic [31:0]    r_addr, w_addr_next;
    logic [255:0]   r_wdata, w_wdata_next;
    logic [63:0]    r_line_beat [4];
    logic [63:0]    w_wr_beat [4];

    logic           w_i_req, w_d_req, w_tie_d, w_grant_d;
    logic [31:0]    w_sel_addr;

    // A D request with both read and write high is malformed and ignored.
    assign w_i_req = bus.i_mem_read;
    assign w_d_req = bus.d_mem_read ^ bus.d_mem_write;

`ifdef ARB_RR_EN
    assign w_tie_d = (r_last_grant == OWNER_I);
`else
    assign w_tie_d = 1'b0;
`endif

    assign w_grant_d  = (w_i_req && w_d_req) ? w_tie_d : w_d_req;
    assign w_sel_addr = w_grant_d ? bus.d_mem_addr : bus.i_mem_addr;

    // State, counter and request latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= 2'd0;
            r_last_grant <= OWNER_D;
            r_owner      <= OWNER_I;
            r_addr       <= 32'd0;
            r_wdata      <= 256'd0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_last_grant <= w_last_grant_next;
            r_owner      <= w_owner_next;
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
        end
    end

    // Next-state: grant in IDLE, count beats in the bursts, pulse in DONE.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_last_grant_next = r_last_grant;
        w_owner_next      = r_owner;
        w_addr_next       = r_addr;
        w_wdata_next      = r_wdata;
        case (r_state)
            IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_owner_next      = w_grant_d;
                    w_last_grant_next = w_grant_d;
                    w_addr_next       = w_sel_addr & 32'hFFFF_FFE0;
                    w_cnt_next        = 2'd0;
                    if (w_grant_d && bus.d_mem_write) begin
                        w_wdata_next = bus.d_mem_wdata;
                        w_state_next = WR_BURST;
                    end else begin
                        w_state_next = RD_BURST;
                    end
                end
            end
            RD_BURST, WR_BURST: begin
                if (bus.pmem_resp) begin
                    w_cnt_next = r_cnt + 2'd1;   // wraps 3->0 on the last beat
                    if (r_cnt == 2'd3) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // One 64-bit lane of the line buffer per beat position.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_wr_beat[gi] = r_wdata[64*gi +: 64];

            // Capture the read beat whose index matches this lane.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_line_beat[gi] <= 64'd0;
                end else if (r_state == RD_BURST && bus.pmem_resp && r_cnt == 2'(gi)) begin
                    r_line_beat[gi] <= bus.pmem_rdata;
                end
            end
        end
    endgenerate

    assign bus.pmem_address = r_addr;
    assign bus.pmem_read    = (r_state == RD_BURST);
    assign bus.pmem_write   = (r_state == WR_BURST);
    assign bus.pmem_wdata   = (r_state == WR_BURST) ? w_wr_beat[r_cnt] : 64'd0;
    assign bus.i_mem_resp   = (r_state == DONE) && (r_owner == OWNER_I);
    assign bus.d_mem_resp   = (r_state == DONE) && (r_owner == OWNER_D);
    assign bus.i_mem_rdata  = {r_line_beat[3], r_line_beat[2], r_line_beat[1], r_line_beat[0]};
    assign bus.d_mem_rdata  = {r_line_beat[3], r_line_beat[2], r_line_beat[1], r_line_beat[0]};
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Testbench for mem_burst_arbiter: scoreboard of expected line transactions
// predicted from the arbitration rules and a line-level memory model, a
// burst-memory responder, and a monitor that checks every burst and response.
module tb_mem_burst_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_burst_arbiter_if bus();
    mem_burst_arbiter dut (.clk(clk), .rst(rst_n), .bus(bus));

    typedef struct {
        bit           owner;      // 0 = I, 1 = D
        bit           is_write;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] line;       // expected line buffer after completion
    } exp_t;

    exp_t         sb_q[$];
    int           n_pass = 0;
    int           n_total = 0;

    bit [63:0]    phys_mem [int unsigned];   // responder's memory, per beat
    logic [255:0] ref_mem  [int unsigned];   // reference memory, per line
    bit           m_last = 1'b1;             // last grant, 1 = D
    logic [255:0] m_buf = '0;

    int           resp_mode = 0;             // 0 no wait, 1 random, 2 gap before beat 2
    logic [63:0]  wcap [4];

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [63:0] beat_init(input int unsigned key);
        return {key, key ^ 32'hC0DE_F00D};
    endfunction

    function automatic logic [63:0] phys_get(input int unsigned key);
        if (phys_mem.exists(key)) return phys_mem[key];
        return beat_init(key);
    endfunction

    function automatic logic [255:0] ref_get(input int unsigned lkey);
        logic [255:0] l;
        if (ref_mem.exists(lkey)) return ref_mem[lkey];
        for (int k = 0; k < 4; k++) l[64*k +: 64] = beat_init(lkey * 4 + k);
        return l;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Record one expected line transaction in grant order.
    function automatic void push_txn(input bit owner, input bit wr, input logic [31:0] addr, input logic [255:0] wd);
        exp_t e;
        int unsigned lkey;
        lkey       = addr >> 5;
        e.owner    = owner;
        e.is_write = wr;
        e.addr     = addr & 32'hFFFF_FFE0;
        e.wdata    = wd;
        if (wr) ref_mem[lkey] = wd;
        else    m_buf = ref_get(lkey);
        e.line = m_buf;
        sb_q.push_back(e);
        m_last = owner;
    endfunction

    // Both caches request in the same idle cycle: winner first, then the other.
    function automatic void issue_pair(input logic [31:0] ia, input bit dwr, input logic [31:0] da, input logic [255:0] dw);
        bit d_first;
`ifdef ARB_RR_EN
        d_first = (m_last == 1'b0);
`else
        d_first = 1'b0;
`endif
        if (d_first) begin
            push_txn(1'b1, dwr, da, dw);
            push_txn(1'b0, 1'b0, ia, '0);
        end else begin
            push_txn(1'b0, 1'b0, ia, '0);
            push_txn(1'b1, dwr, da, dw);
        end
    endfunction

    function automatic int pick_wait(input int b);
        if (resp_mode == 1) return $urandom_range(0, 2);
        if (resp_mode == 2) return (b == 2) ? 2 : 0;
        return 0;
    endfunction

    // Burst memory responder: drives pmem_resp/pmem_rdata for the next edge.
    initial begin
        int beat;
        int wait_left;
        bit wait_armed;
        int unsigned key;
        beat = 0; wait_left = 0; wait_armed = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.pmem_resp = 1'b0;
                beat = 0;
                wait_armed = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (!wait_armed) begin
                    wait_left  = pick_wait(beat);
                    wait_armed = 1;
                end
                if (wait_left > 0) begin
                    wait_left--;
                    bus.pmem_resp  = 1'b0;
                    bus.pmem_rdata = {$urandom, $urandom};
                end else begin
                    key = (bus.pmem_address >> 3) + beat;
                    if (bus.pmem_read) begin
                        bus.pmem_rdata = phys_get(key);
                    end else begin
                        phys_mem[key] = bus.pmem_wdata;
                        if (beat < 4) wcap[beat] = bus.pmem_wdata;
                    end
                    bus.pmem_resp = 1'b1;
                    beat++;
                    wait_armed = 0;
                end
            end else begin
                beat = 0;
                wait_armed = 0;
                bus.pmem_resp  = (resp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.pmem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Monitor: checks each burst start and each response against the scoreboard.
    initial begin
        bit   prev_in;
        bit   in_b;
        exp_t e;
        prev_in = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_in = 0;
            end else begin
                in_b = bus.pmem_read || bus.pmem_write;
                if (in_b && !prev_in) begin
                    if (sb_q.size() == 0) begin
                        check("burst_without_request", 256'(in_b), 0);
                    end else begin
                        check("pmem_address", bus.pmem_address, sb_q[0].addr);
                        check("pmem_write_op", bus.pmem_write, sb_q[0].is_write);
                    end
                end
                prev_in = in_b;
                if (bus.i_mem_resp || bus.d_mem_resp) begin
                    check("resp_exclusive", bus.i_mem_resp & bus.d_mem_resp, 0);
                    if (sb_q.size() == 0) begin
                        check("resp_without_request", bus.i_mem_resp | bus.d_mem_resp, 0);
                    end else begin
                        e = sb_q.pop_front();
                        $display("txn owner=%s op=%s addr=%h i_resp=%0b d_resp=%0b",
                                 e.owner ? "D" : "I", e.is_write ? "WR" : "RD", e.addr,
                                 bus.i_mem_resp, bus.d_mem_resp);
                        check("resp_owner", bus.d_mem_resp, e.owner);
                        check("i_mem_rdata", bus.i_mem_rdata, e.line);
                        check("d_mem_rdata", bus.d_mem_rdata, e.line);
                        if (e.is_write)
                            check("write_beats", {wcap[3], wcap[2], wcap[1], wcap[0]}, e.wdata);
                    end
                end
            end
        end
    end

    // Drop each request on its response; finish when all requests are gone.
    task automatic wait_round(input int budget);
        int cyc;
        cyc = 0;
        while ((bus.i_mem_read || bus.d_mem_read || bus.d_mem_write) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.i_mem_resp) begin
                bus.i_mem_read = 1'b0;
                bus.i_mem_addr = $urandom;
            end
            if (bus.d_mem_resp) begin
                bus.d_mem_read  = 1'b0;
                bus.d_mem_write = 1'b0;
                bus.d_mem_addr  = $urandom;
                bus.d_mem_wdata = rand256();
            end
        end
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        if (sb_q.size() != 0) do_reset();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_mem_read  = 1'b0;
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
        sb_q.delete();
        m_last = 1'b1;
        m_buf  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        logic [31:0]  a;
        logic [255:0] l;
        int i_cyc, rd_cycles;
        bit i_seen, d_seen;
        a = 32'h1000_0024;
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        for (int k = 0; k < 4; k++) phys_mem[(a >> 3) - 32'd0 + 32'(k) - 32'd0 - ((a >> 3) & 32'd3)] = l[64*k +: 64];
        ref_mem[a >> 5] = l;
        resp_mode = 0;
        i_cyc = -1; rd_cycles = 0; i_seen = 0; d_seen = 0;
        bus.i_mem_addr = a;
        bus.i_mem_read = 1'b1;
        push_txn(1'b0, 1'b0, a, '0);
        for (int k = 1; k <= 30 && !i_seen; k++) begin
            @(negedge clk);
            if (bus.pmem_read) rd_cycles++;
            if (bus.d_mem_resp) d_seen = 1;
            if (bus.i_mem_resp) begin
                i_seen = 1;
                i_cyc = k;
                bus.i_mem_read = 1'b0;
            end
        end
        check("single_read_resp_cycle", 256'(i_cyc), 256'(5));
        check("single_read_beat_cycles", 256'(rd_cycles), 256'(4));
        @(negedge clk);
        check("single_read_resp_one_cycle", bus.i_mem_resp, 0);
        check("single_read_no_d_resp", 256'(d_seen | bus.d_mem_resp), 0);
        check("single_read_line", bus.i_mem_rdata, l);
    endtask

    task automatic test_write_gap();
        logic [31:0]  a;
        logic [255:0] w;
        int d_cyc, wr_cycles;
        bit d_seen;
        a = 32'h2000_0040;
        w = rand256();
        resp_mode = 2;
        d_cyc = -1; wr_cycles = 0; d_seen = 0;
        bus.d_mem_addr  = a;
        bus.d_mem_wdata = w;
        bus.d_mem_write = 1'b1;
        push_txn(1'b1, 1'b1, a, w);
        for (int k = 1; k <= 30 && !d_seen; k++) begin
            @(negedge clk);
            if (bus.pmem_write) wr_cycles++;
            if (bus.d_mem_resp) begin
                d_seen = 1;
                d_cyc = k;
                bus.d_mem_write = 1'b0;
                bus.d_mem_wdata = rand256();
            end
        end
        check("write_gap_resp_cycle", 256'(d_cyc), 256'(7));
        check("write_gap_pmem_write_cycles", 256'(wr_cycles), 256'(6));
        @(negedge clk);
        check("write_gap_resp_one_cycle", bus.d_mem_resp, 0);
        // Read the line back through the I side.
        resp_mode = 1;
        bus.i_mem_addr = a + 32'd5;
        bus.i_mem_read = 1'b1;
        push_txn(1'b0, 1'b0, a + 32'd5, '0);
        wait_round(100);
    endtask

    task automatic test_bad_d_request();
        int active;
        bit any_resp;
        active = 0; any_resp = 0;
        resp_mode = 0;
        bus.d_mem_addr  = 32'h3000_0000;
        bus.d_mem_read  = 1'b1;
        bus.d_mem_write = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.pmem_read || bus.pmem_write) active++;
            if (bus.i_mem_resp || bus.d_mem_resp) any_resp = 1;
        end
        check("bad_d_no_burst", 256'(active), 0);
        check("bad_d_no_resp", 256'(any_resp), 0);
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention_from_reset();
        logic [31:0] ia, da;
        int first_owner;
        do_reset();
        resp_mode = 1;
        for (int r = 0; r < 2; r++) begin
            ia = 32'h4000_0000 + 32'($urandom_range(0, 255));
            da = 32'h4800_0000 + 32'($urandom_range(0, 255));
            bus.i_mem_addr = ia;
            bus.i_mem_read = 1'b1;
            bus.d_mem_addr = da;
            bus.d_mem_read = 1'b1;
            if (r == 0) begin
                // From reset, I is served first in either configuration.
                check("contention_first_pred_i", 256'(m_last), 256'(1));
            end
            issue_pair(ia, 1'b0, da, '0);
            first_owner = -1;
            for (int k = 0; k < 40 && first_owner < 0; k++) begin
                @(negedge clk);
                if (bus.i_mem_resp) first_owner = 0;
                else if (bus.d_mem_resp) first_owner = 1;
            end
            if (r == 0) check("contention_first_owner_i", 256'(first_owner), 0);
            if (bus.i_mem_resp) bus.i_mem_read = 1'b0;
            if (bus.d_mem_resp) bus.d_mem_read = 1'b0;
            wait_round(100);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] a;
        bit resp_seen;
        resp_mode = 0;
        resp_seen = 0;
        a = 32'h5000_0100;
        bus.i_mem_addr = a;
        bus.i_mem_read = 1'b1;
        push_txn(1'b0, 1'b0, a, '0);
        repeat (3) @(negedge clk);    // two beats accepted, third pending
        rst_n = 1'b0;
        bus.i_mem_read = 1'b0;
        sb_q.delete();
        m_last = 1'b1;
        m_buf  = '0;
        #1;
        check("abort_pmem_read", bus.pmem_read, 0);
        check("abort_i_resp", bus.i_mem_resp, 0);
        check("abort_buffer_cleared", bus.i_mem_rdata, 0);
        repeat (3) begin
            @(negedge clk);
            if (bus.i_mem_resp || bus.d_mem_resp) resp_seen = 1;
        end
        check("abort_no_resp", 256'(resp_seen), 0);
        rst_n = 1'b1;
        @(negedge clk);
        a = 32'h5000_0200 + 32'($urandom_range(0, 31));
        bus.i_mem_addr = a;
        bus.i_mem_read = 1'b1;
        push_txn(1'b0, 1'b0, a, '0);
        wait_round(60);
    endtask

    task automatic test_random(input int rounds);
        int pat;
        bit dwr;
        logic [31:0]  ia, da;
        logic [255:0] dw;
        resp_mode = 1;
        for (int r = 0; r < rounds; r++) begin
            pat = $urandom_range(0, 3);
            dwr = 1'($urandom_range(0, 1));
            ia  = 32'h2000_0000 + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31));
            da  = 32'h2000_0000 + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31));
            dw  = rand256();
            if (pat == 0 || pat >= 2) begin
                bus.i_mem_addr = ia;
                bus.i_mem_read = 1'b1;
            end
            if (pat >= 1) begin
                bus.d_mem_addr  = da;
                bus.d_mem_wdata = dw;
                bus.d_mem_read  = ~dwr;
                bus.d_mem_write = dwr;
            end
            if (pat == 0)      push_txn(1'b0, 1'b0, ia, '0);
            else if (pat == 1) push_txn(1'b1, dwr, da, dw);
            else               issue_pair(ia, dwr, da, dw);
            wait_round(300);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_mem_addr  = '0;
        bus.i_mem_read  = 1'b0;
        bus.d_mem_addr  = '0;
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
        bus.d_mem_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_i_resp", bus.i_mem_resp, 0);
        check("reset_d_resp", bus.d_mem_resp, 0);
        check("reset_pmem_read", bus.pmem_read, 0);
        check("reset_pmem_write", bus.pmem_write, 0);
        check("reset_pmem_address", bus.pmem_address, 0);
        check("reset_pmem_wdata", bus.pmem_wdata, 0);
        check("reset_i_rdata", bus.i_mem_rdata, 0);
        check("reset_d_rdata", bus.d_mem_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        test_single_read();
        test_write_gap();
        test_bad_d_request();
        test_contention_from_reset();
        test_reset_mid_burst();
        test_random(40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
